mips_ctrl_pipe: RTL and testbench

//  Registered, parametrised successor to the per-opcode control units. Decodes the ID-stage

---
 rtl/mips_ctrl_pipe.sv | 188 ++++++++++++++++++
 tb/tb_mips_ctrl_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_ctrl_pipe.sv
// Pipelined MIPS control unit: decodes the ID opcode into a control word carried through
// EX/MEM/WB, resolves BEQZ/BNEQZ in EX with a one-slot flush, and drains the pipe on HLT.
module mips_ctrl_pipe #(
    parameter int unsigned     OP_W    = 6,
    parameter int unsigned     ALUOP_W = 3,
    parameter logic [OP_W-1:0] HLT_OP  = OP_W'(63),
    parameter int unsigned     CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [OP_W-1:0]    id_opcode,
    input  logic               stall,
    input  logic               ex_zero,
    output logic               ex_sel_a,
    output logic               ex_sel_b,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               branch_taken,
    output logic               pc_write_en,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               wb_reg_wr,
    output logic               wb_sel_mem,
    output logic               halted,
    output logic [CNT_W-1:0]   illegal_cnt,
    output logic [CNT_W-1:0]   retire_cnt
);

    typedef struct packed {
        logic               sel_a;
        logic               sel_b;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_rd;
        logic               mem_wr;
        logic               reg_wr;
        logic               sel_mem;
        logic               beqz;
        logic               bneqz;
        logic               hlt;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_rd;
        logic mem_wr;
        logic reg_wr;
        logic sel_mem;
        logic hlt;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_wr;
        logic sel_mem;
    } wb_ctrl_t;

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e     state_q, state_d;
    logic       ex_valid_q, ex_valid_d;
    ex_ctrl_t   ex_q, ex_d;
    logic       mem_valid_q, mem_valid_d;
    mem_ctrl_t  mem_q, mem_d;
    logic       wb_valid_q, wb_valid_d;
    wb_ctrl_t   wb_q, wb_d;
    logic [CNT_W-1:0] illegal_q, illegal_d;
    logic [CNT_W-1:0] retire_q, retire_d;

    ex_ctrl_t dec;
    logic     dec_legal;
    logic     hlt_in_ex;
    logic     id_take;
    logic     active;

    always_comb begin
        dec       = '0;
        dec_legal = 1'b0;
        // HLT is checked first so a parameterised HLT_OP wins over any class range.
        if (id_opcode == HLT_OP) begin
            dec_legal = 1'b1;
            dec.hlt   = 1'b1;
        end else if (id_opcode <= OP_W'(5)) begin
            dec_legal  = 1'b1;
            dec.sel_a  = 1'b1;
            dec.sel_b  = 1'b1;
            dec.alu_op = id_opcode[ALUOP_W-1:0];
            dec.reg_wr = 1'b1;
        end else if (id_opcode == OP_W'(8)) begin
            dec_legal   = 1'b1;
            dec.sel_a   = 1'b1;
            dec.mem_rd  = 1'b1;
            dec.reg_wr  = 1'b1;
            dec.sel_mem = 1'b1;
        end else if (id_opcode == OP_W'(9)) begin
            dec_legal  = 1'b1;
            dec.sel_a  = 1'b1;
            dec.mem_wr = 1'b1;
        end else if (id_opcode >= OP_W'(10) && id_opcode <= OP_W'(12)) begin
            dec_legal  = 1'b1;
            dec.sel_a  = 1'b1;
            dec.alu_op = id_opcode[ALUOP_W-1:0];
            dec.reg_wr = 1'b1;
        end else if (id_opcode == OP_W'(13)) begin
            dec_legal = 1'b1;
            dec.bneqz = 1'b1;
        end else if (id_opcode == OP_W'(14)) begin
            dec_legal = 1'b1;
            dec.beqz  = 1'b1;
        end
    end

    assign hlt_in_ex    = ex_valid_q & ex_q.hlt;
    assign branch_taken = ex_valid_q & ((ex_q.beqz & ex_zero) | (ex_q.bneqz & ~ex_zero));
    // A taken branch squashes the ID slot even when a stall is also raised.
    assign id_take      = (state_q == StRun) & ~hlt_in_ex & id_valid & ~stall & ~branch_taken;
    assign active       = (state_q != StHalted);

    always_comb begin
        ex_valid_d  = id_take & dec_legal;
        ex_d        = (id_take & dec_legal) ? dec : '0;

        mem_valid_d   = ex_valid_q;
        mem_d         = '0;
        mem_d.mem_rd  = ex_q.mem_rd;
        mem_d.mem_wr  = ex_q.mem_wr;
        mem_d.reg_wr  = ex_q.reg_wr;
        mem_d.sel_mem = ex_q.sel_mem;
        mem_d.hlt     = ex_q.hlt;

        wb_valid_d   = mem_valid_q;
        wb_d         = '0;
        wb_d.reg_wr  = mem_q.reg_wr;
        wb_d.sel_mem = mem_q.sel_mem;

        illegal_d = illegal_q;
        if (id_take & ~dec_legal & ~(&illegal_q)) begin
            illegal_d = illegal_q + CNT_W'(1);
        end
        retire_d = retire_q;
        if (wb_valid_q & ~(&retire_q)) begin
            retire_d = retire_q + CNT_W'(1);
        end

        state_d = state_q;
        unique case (state_q)
            StRun:    if (hlt_in_ex) state_d = StDrain;
            // HLT sits in MEM on the first drain cycle; everything older is already past EX.
            StDrain:  if (mem_valid_q & mem_q.hlt) state_d = StHalted;
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            ex_valid_q  <= 1'b0;
            ex_q        <= '0;
            mem_valid_q <= 1'b0;
            mem_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_q        <= '0;
            illegal_q   <= '0;
            retire_q    <= '0;
        end else begin
            state_q     <= state_d;
            ex_valid_q  <= ex_valid_d;
            ex_q        <= ex_d;
            mem_valid_q <= mem_valid_d;
            mem_q       <= mem_d;
            wb_valid_q  <= wb_valid_d;
            wb_q        <= wb_d;
            illegal_q   <= illegal_d;
            retire_q    <= retire_d;
        end
    end

    assign ex_sel_a    = active & ex_valid_q & ex_q.sel_a;
    assign ex_sel_b    = active & ex_valid_q & ex_q.sel_b;
    assign ex_alu_op   = (active & ex_valid_q) ? ex_q.alu_op : '0;
    assign mem_rd      = active & mem_valid_q & mem_q.mem_rd;
    assign mem_wr      = active & mem_valid_q & mem_q.mem_wr;
    assign wb_reg_wr   = active & wb_valid_q & wb_q.reg_wr;
    assign wb_sel_mem  = active & wb_valid_q & wb_q.sel_mem;
    assign pc_write_en = ~stall & (state_q == StRun) & ~hlt_in_ex;
    assign halted      = (state_q == StHalted);
    assign illegal_cnt = illegal_q;
    assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// Directed bench for mips_ctrl_pipe: per-stage control expectations are queued at issue time
// and checked in the cycle the instruction reaches EX, MEM and WB.
module tb_mips_ctrl_pipe;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic       stall;
    logic       ex_zero;

    logic        ex_sel_a, ex_sel_b, branch_taken, pc_write_en;
    logic [2:0]  ex_alu_op;
    logic        mem_rd, mem_wr, wb_reg_wr, wb_sel_mem, halted;
    logic [15:0] illegal_cnt, retire_cnt;

    logic       s_sel_a, s_sel_b, s_bt, s_pcw, s_mem_rd, s_mem_wr, s_wb_wr, s_wb_mem, s_halted;
    logic [2:0] s_alu_op;
    logic [1:0] s_illegal, s_retire;

    mips_ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .stall(stall), .ex_zero(ex_zero), .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b),
        .ex_alu_op(ex_alu_op), .branch_taken(branch_taken), .pc_write_en(pc_write_en),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_reg_wr(wb_reg_wr), .wb_sel_mem(wb_sel_mem),
        .halted(halted), .illegal_cnt(illegal_cnt), .retire_cnt(retire_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, for saturation.
    mips_ctrl_pipe #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .stall(stall), .ex_zero(ex_zero), .ex_sel_a(s_sel_a), .ex_sel_b(s_sel_b),
        .ex_alu_op(s_alu_op), .branch_taken(s_bt), .pc_write_en(s_pcw),
        .mem_rd(s_mem_rd), .mem_wr(s_mem_wr), .wb_reg_wr(s_wb_wr), .wb_sel_mem(s_wb_mem),
        .halted(s_halted), .illegal_cnt(s_illegal), .retire_cnt(s_retire)
    );

    logic [10:0] outs;
    assign outs = {ex_sel_a, ex_sel_b, ex_alu_op, branch_taken, mem_rd, mem_wr,
                   wb_reg_wr, wb_sel_mem, halted};

    typedef struct {
        int         due;
        int         kind;
        logic [4:0] val;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  exp_retire = 0;
    int  exp_illegal = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {sel_a, sel_b, alu_op[2:0], mem_rd, mem_wr, reg_wr, sel_mem}
    function automatic logic [8:0] exp_word(input logic [5:0] op);
        if (op <= 6'd5)                    return {2'b11, op[2:0], 4'b0010};
        if (op == 6'd8)                    return {2'b10, 3'd0, 4'b1011};
        if (op == 6'd9)                    return {2'b10, 3'd0, 4'b0100};
        if (op >= 6'd10 && op <= 6'd12)    return {2'b10, op[2:0], 4'b0010};
        return 9'd0;
    endfunction

    task automatic push3(input int k, input logic [8:0] w);
        sb.push_back('{due: k + 1, kind: 0, val: w[8:4]});
        sb.push_back('{due: k + 2, kind: 1, val: {3'b000, w[3:2]}});
        sb.push_back('{due: k + 3, kind: 2, val: {3'b000, w[1:0]}});
    endtask

    task automatic push_op(input logic [5:0] op);
        push3(cyc, exp_word(op));
        exp_retire++;
    endtask

    task automatic push_bubble();
        push3(cyc, 9'd0);
    endtask

    always @(negedge clk) begin
        sb_t keep[$];
        logic [4:0] obs;
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].due <= cyc) begin
                if (sb[i].due < cyc) begin
                    chk($sformatf("sb_stale_k%0d_d%0d", sb[i].kind, sb[i].due), 32'd1, 32'd0);
                end else begin
                    case (sb[i].kind)
                        0:       obs = {ex_sel_a, ex_sel_b, ex_alu_op};
                        1:       obs = {3'b000, mem_rd, mem_wr};
                        default: obs = {3'b000, wb_reg_wr, wb_sel_mem};
                    endcase
                    chk($sformatf("stage%0d_c%0d", sb[i].kind, sb[i].due), 32'(obs),
                        32'(sb[i].val));
                end
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic issue(input logic v, input logic [5:0] op, input logic st, input logic z);
        @(posedge clk);
        #1;
        id_valid  = v;
        id_opcode = op;
        stall     = st;
        ex_zero   = z;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            issue(1'b0, 6'd0, 1'b0, 1'b0);
            push_bubble();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0;
        id_opcode = 6'd0;
        stall = 1'b0;
        ex_zero = 1'b0;
        #12;
        chk("rst_outs", 32'(outs), 32'd0);
        chk("rst_retire", 32'(retire_cnt), 32'd0);
        chk("rst_illegal", 32'(illegal_cnt), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rel_pcw", 32'(pc_write_en), 32'd1);

        // Back-to-back ADD, LW, SW, ADDI
        issue(1, 6'd0, 0, 0);  push_op(6'd0);
        issue(1, 6'd8, 0, 0);  push_op(6'd8);
        issue(1, 6'd9, 0, 0);  push_op(6'd9);
        issue(1, 6'd10, 0, 0); push_op(6'd10);
        idle(4);
        @(negedge clk) chk("t1_retire", 32'(retire_cnt), 32'd4);

        // Branches: taken squashes the following ADD, not-taken lets it through
        issue(1, 6'd14, 0, 0); push_op(6'd14);
        issue(1, 6'd0, 0, 1);  push_bubble();
        @(negedge clk) chk("beqz_taken", 32'(branch_taken), 32'd1);
        chk("beqz_pcw", 32'(pc_write_en), 32'd1);
        issue(0, 6'd0, 0, 1);  push_bubble();
        @(negedge clk) chk("beqz_one_cycle", 32'(branch_taken), 32'd0);
        issue(1, 6'd14, 0, 0); push_op(6'd14);
        issue(1, 6'd0, 0, 0);  push_op(6'd0);
        @(negedge clk) chk("beqz_not_taken", 32'(branch_taken), 32'd0);
        issue(1, 6'd13, 0, 0); push_op(6'd13);
        issue(1, 6'd0, 0, 0);  push_bubble();
        @(negedge clk) chk("bneqz_taken", 32'(branch_taken), 32'd1);
        issue(1, 6'd13, 0, 0); push_op(6'd13);
        issue(1, 6'd0, 0, 1);  push_op(6'd0);
        @(negedge clk) chk("bneqz_not_taken", 32'(branch_taken), 32'd0);
        idle(4);
        @(negedge clk) chk("t2_retire", 32'(retire_cnt), 32'(exp_retire));

        // Two-cycle stall on SUB with an older ADDI still draining
        issue(1, 6'd10, 0, 0); push_op(6'd10);
        issue(1, 6'd1, 1, 0);  push_bubble();
        @(negedge clk) chk("stall1_pcw", 32'(pc_write_en), 32'd0);
        issue(1, 6'd1, 1, 0);  push_bubble();
        @(negedge clk) chk("stall2_pcw", 32'(pc_write_en), 32'd0);
        issue(1, 6'd1, 0, 0);  push_op(6'd1);
        @(negedge clk) chk("stall_rel_pcw", 32'(pc_write_en), 32'd1);
        idle(4);
        @(negedge clk) chk("t3_retire", 32'(retire_cnt), 32'(exp_retire));

        // Illegal opcodes interleaved with ADD
        issue(1, 6'd6, 0, 0);  push_bubble(); exp_illegal++;
        issue(1, 6'd0, 0, 0);  push_op(6'd0);
        issue(1, 6'd7, 0, 0);  push_bubble(); exp_illegal++;
        issue(1, 6'd0, 0, 0);  push_op(6'd0);
        issue(1, 6'd20, 0, 0); push_bubble(); exp_illegal++;
        idle(2);
        @(negedge clk) chk("ill3", 32'(illegal_cnt), 32'(exp_illegal));
        chk("ill3_small", 32'(s_illegal), 32'd3);
        issue(1, 6'd21, 0, 0); push_bubble(); exp_illegal++;
        issue(1, 6'd30, 0, 0); push_bubble(); exp_illegal++;
        idle(1);
        @(negedge clk) chk("ill5", 32'(illegal_cnt), 32'(exp_illegal));
        chk("ill5_small_sat", 32'(s_illegal), 32'd3);
        idle(3);
        @(negedge clk) chk("t4_retire", 32'(retire_cnt), 32'(exp_retire));

        // Stall together with a taken branch: flush wins, one bubble
        issue(1, 6'd14, 0, 0); push_op(6'd14);
        issue(1, 6'd0, 1, 1);  push_bubble();
        @(negedge clk) chk("flush_stall_bt", 32'(branch_taken), 32'd1);
        chk("flush_stall_pcw", 32'(pc_write_en), 32'd0);
        issue(1, 6'd2, 0, 0);  push_op(6'd2);
        @(negedge clk) chk("flush_after_pcw", 32'(pc_write_en), 32'd1);
        idle(4);
        @(negedge clk) chk("t6_retire", 32'(retire_cnt), 32'(exp_retire));

        // ADDI, HLT, ADD: drain then halt
        issue(1, 6'd10, 0, 0); push_op(6'd10);
        issue(1, 6'd63, 0, 0); push_op(6'd63);
        @(negedge clk) chk("hlt_id_pcw", 32'(pc_write_en), 32'd1);
        issue(1, 6'd0, 0, 0);  push_bubble();
        @(negedge clk) chk("hlt_ex_pcw", 32'(pc_write_en), 32'd0);
        chk("hlt_ex_halted", 32'(halted), 32'd0);
        issue(1, 6'd0, 0, 0);  push_bubble();
        @(negedge clk) chk("drain_halted", 32'(halted), 32'd0);
        chk("drain_pcw", 32'(pc_write_en), 32'd0);
        issue(1, 6'd0, 0, 0);  push_bubble();
        @(negedge clk) chk("halted", 32'(halted), 32'd1);
        issue(1, 6'd6, 0, 0);  push_bubble();
        issue(1, 6'd0, 1, 0);  push_bubble();
        idle(3);
        @(negedge clk) chk("halt_stays", 32'(halted), 32'd1);
        chk("halt_retire", 32'(retire_cnt), 32'(exp_retire));
        chk("halt_illegal", 32'(illegal_cnt), 32'(exp_illegal));
        chk("halt_pcw", 32'(pc_write_en), 32'd0);

        // Reset out of HALTED, then reset in the middle of a drain
        #1 rst_n = 1'b0;
        sb.delete();
        exp_retire = 0;
        exp_illegal = 0;
        #1 chk("rst2_halted", 32'(halted), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        issue(1, 6'd63, 0, 0); push_op(6'd63);
        issue(0, 6'd0, 0, 0);  push_bubble();
        @(negedge clk) chk("md_hlt_ex_pcw", 32'(pc_write_en), 32'd0);
        issue(0, 6'd0, 0, 0);  push_bubble();
        @(negedge clk) chk("md_drain_halted", 32'(halted), 32'd0);
        #1 rst_n = 1'b0;
        sb.delete();
        exp_retire = 0;
        #1 chk("md_rst_outs", 32'(outs), 32'd0);
        chk("md_rst_retire", 32'(retire_cnt), 32'd0);
        chk("md_rst_illegal", 32'(illegal_cnt), 32'd0);
        chk("md_rst_pcw", 32'(pc_write_en), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        issue(1, 6'd3, 0, 0);  push_op(6'd3);
        idle(4);
        @(negedge clk) chk("md_run_retire", 32'(retire_cnt), 32'(exp_retire));
        chk("md_run_halted", 32'(halted), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
